// File: rtl/ucaspian_host_pkg.sv
// rtl/ucaspian_host_pkg.sv - host command opcodes, payload length table and deframer states
package ucaspian_host_pkg;

  localparam logic [7:0] OP_NOOP        = 8'h00;
  localparam logic [7:0] OP_CLEAR       = 8'h01;
  localparam logic [7:0] OP_STEP        = 8'h02;
  localparam logic [7:0] OP_FIRE        = 8'h03;
  localparam logic [7:0] OP_CFG_NEURON  = 8'h10;
  localparam logic [7:0] OP_CFG_SYNAPSE = 8'h11;
  localparam logic [7:0] OP_READ_METRIC = 8'h20;

  typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD} deframer_state_t;

  typedef struct packed {
    logic       known;
    logic [3:0] len;
  } op_info_t;

  function automatic op_info_t op_len(input logic [7:0] op);
    op_info_t r;
    r.known = 1'b1;
    r.len   = 4'd0;
    case (op)
      OP_NOOP, OP_CLEAR:             r.len = 4'd0;
      OP_STEP, OP_FIRE:              r.len = 4'd2;
      OP_CFG_NEURON, OP_CFG_SYNAPSE: r.len = 4'd4;
      OP_READ_METRIC:                r.len = 4'd1;
      default:                       r.known = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/host_cmd_deframer.sv
// rtl/host_cmd_deframer.sv - splits the SPI byte stream into opcode+payload host commands
module host_cmd_deframer
  import ucaspian_host_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int ERR_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [7:0]                   in_data,
  input  logic                         in_vld,
  output logic                         in_rdy,
  output logic [7:0]                   out_op,
  output logic [MAX_BYTES*8-1:0]       out_payload,
  output logic [$clog2(MAX_BYTES+1)-1:0] out_len,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         busy,
  output logic                         err_unknown,
  output logic [ERR_W-1:0]             err_count
);

  localparam int PW = MAX_BYTES * 8;
  localparam int LW = $clog2(MAX_BYTES + 1);

  deframer_state_t state;
  logic [LW-1:0]   remaining;
  op_info_t        dec;
  logic            in_xfer;

  assign dec     = op_len(in_data);
  assign in_rdy  = !flush && (state == IDLE || state == PAYLOAD);
  assign busy    = (state == PAYLOAD) || (state == HOLD);
  assign in_xfer = in_vld && in_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      remaining   <= '0;
      out_op      <= '0;
      out_payload <= '0;
      out_len     <= '0;
      out_vld     <= 1'b0;
      err_unknown <= 1'b0;
      err_count   <= '0;
    end else begin
      err_unknown <= 1'b0;
      if (flush) begin
        // a handshake coinciding with flush is void; the held command is simply dropped
        state     <= IDLE;
        out_vld   <= 1'b0;
        remaining <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_xfer) begin
              if (!dec.known) begin
                err_unknown <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
              end else begin
                out_op      <= in_data;
                out_payload <= '0;
                out_len     <= LW'(dec.len);
                remaining   <= LW'(dec.len);
                if (dec.len == 4'd0) begin
                  state   <= HOLD;
                  out_vld <= 1'b1;
                end else begin
                  state <= PAYLOAD;
                end
              end
            end
          end
          PAYLOAD: begin
            if (in_xfer) begin
              out_payload <= {out_payload[PW-9:0], in_data};
              remaining   <= remaining - 1'b1;
              if (remaining == LW'(1)) begin
                state   <= HOLD;
                out_vld <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (out_rdy) begin
              state   <= IDLE;
              out_vld <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_deframer.sv
// tb/tb_host_cmd_deframer.sv - directed vector bench for host_cmd_deframer
module tb_host_cmd_deframer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  out_op;
  logic [31:0] out_payload;
  logic [2:0]  out_len;
  logic        out_vld;
  logic        out_rdy;
  logic        busy;
  logic        err_unknown;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  host_cmd_deframer #(.MAX_BYTES(4), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_op(out_op), .out_payload(out_payload), .out_len(out_len),
    .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy),
    .err_unknown(err_unknown), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        e_rdy;
    logic        e_vld;
    logic        e_busy;
    logic        e_eu;
    logic [7:0]  e_op;
    logic [31:0] e_pl;
    logic [2:0]  e_len;
    logic [7:0]  e_ec;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic vld, input logic [7:0] d, input logic rdy,
                     input logic e_rdy, input logic e_vld, input logic e_busy, input logic e_eu,
                     input logic [7:0] e_op, input logic [31:0] e_pl, input logic [2:0] e_len,
                     input logic [7:0] e_ec);
    vec_t v;
    v.vld = vld; v.d = d; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_busy = e_busy; v.e_eu = e_eu;
    v.e_op = e_op; v.e_pl = e_pl; v.e_len = e_len; v.e_ec = e_ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic e_rdy, input logic e_vld,
                         input logic e_busy, input logic e_eu, input logic [7:0] e_op,
                         input logic [31:0] e_pl, input logic [2:0] e_len, input logic [7:0] e_ec);
    chk({tag, ".in_rdy"}, idx, 32'(in_rdy), 32'(e_rdy));
    chk({tag, ".out_vld"}, idx, 32'(out_vld), 32'(e_vld));
    chk({tag, ".busy"}, idx, 32'(busy), 32'(e_busy));
    chk({tag, ".err_unknown"}, idx, 32'(err_unknown), 32'(e_eu));
    chk({tag, ".out_op"}, idx, 32'(out_op), 32'(e_op));
    chk({tag, ".out_payload"}, idx, out_payload, e_pl);
    chk({tag, ".out_len"}, idx, 32'(out_len), 32'(e_len));
    chk({tag, ".err_count"}, idx, 32'(err_count), 32'(e_ec));
  endtask

  // drive at the falling edge, let one rising edge pass, return at the next falling edge
  task automatic step(input logic vld, input logic [7:0] d, input logic rdy, input logic fl);
    in_vld = vld; in_data = d; out_rdy = rdy; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_data = 8'h00; in_vld = 1'b0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 1, 0, 0, 0, 8'h00, 32'h0, 3'd0, 8'd0);
    reset = 1'b1;
    @(negedge clk);

    //  vld  d      rdy  rdy vld busy eu  op     payload        len ec
    add(1, 8'h10, 1,   1, 0, 1, 0, 8'h10, 32'h00000000, 4, 0);
    add(1, 8'hDE, 1,   1, 0, 1, 0, 8'h10, 32'h000000DE, 4, 0);
    add(1, 8'hAD, 1,   1, 0, 1, 0, 8'h10, 32'h0000DEAD, 4, 0);
    add(1, 8'hBE, 1,   1, 0, 1, 0, 8'h10, 32'h00DEADBE, 4, 0);
    add(1, 8'hEF, 1,   0, 1, 1, 0, 8'h10, 32'hDEADBEEF, 4, 0);
    add(0, 8'h00, 1,   1, 0, 0, 0, 8'h10, 32'hDEADBEEF, 4, 0);
    add(1, 8'h03, 0,   1, 0, 1, 0, 8'h03, 32'h00000000, 2, 0);
    add(0, 8'h55, 0,   1, 0, 1, 0, 8'h03, 32'h00000000, 2, 0);
    add(1, 8'h12, 0,   1, 0, 1, 0, 8'h03, 32'h00000012, 2, 0);
    add(0, 8'h55, 0,   1, 0, 1, 0, 8'h03, 32'h00000012, 2, 0);
    add(1, 8'h34, 0,   0, 1, 1, 0, 8'h03, 32'h00001234, 2, 0);
    for (int k = 0; k < 5; k++)
      add(1, 8'h99, 0, 0, 1, 1, 0, 8'h03, 32'h00001234, 2, 0);
    add(0, 8'h00, 1,   1, 0, 0, 0, 8'h03, 32'h00001234, 2, 0);
    add(1, 8'h7F, 1,   1, 0, 0, 1, 8'h03, 32'h00001234, 2, 1);
    add(1, 8'h01, 0,   0, 1, 1, 0, 8'h01, 32'h00000000, 0, 1);
    add(0, 8'h00, 1,   1, 0, 0, 0, 8'h01, 32'h00000000, 0, 1);
    add(1, 8'h00, 0,   0, 1, 1, 0, 8'h00, 32'h00000000, 0, 1);
    add(0, 8'h00, 1,   1, 0, 0, 0, 8'h00, 32'h00000000, 0, 1);
    add(1, 8'h20, 1,   1, 0, 1, 0, 8'h20, 32'h00000000, 1, 1);
    add(1, 8'h7F, 0,   0, 1, 1, 0, 8'h20, 32'h0000007F, 1, 1);
    add(0, 8'h00, 1,   1, 0, 0, 0, 8'h20, 32'h0000007F, 1, 1);

    foreach (vq[i]) begin
      step(vq[i].vld, vq[i].d, vq[i].rdy, 1'b0);
      chk_all("vec", i, vq[i].e_rdy, vq[i].e_vld, vq[i].e_busy, vq[i].e_eu,
              vq[i].e_op, vq[i].e_pl, vq[i].e_len, vq[i].e_ec);
    end

    // 300 unknown opcodes: counter climbs from 1 and saturates at 255
    for (int k = 0; k < 300; k++) begin
      step(1, 8'hFF, 1, 1'b0);
      chk("sat.err_unknown", k, 32'(err_unknown), 32'd1);
      chk("sat.out_vld", k, 32'(out_vld), 32'd0);
    end
    chk("sat.err_count", 0, 32'(err_count), 32'd255);
    step(0, 8'h00, 1, 1'b0);
    chk("sat.pulse_end", 0, 32'(err_unknown), 32'd0);

    // flush mid-payload: partial 0x11 dropped, byte offered during flush not taken
    step(1, 8'h11, 1, 1'b0);
    step(1, 8'hAA, 1, 1'b0);
    in_vld = 1'b1; in_data = 8'h20; flush = 1'b1;
    #1 chk("flush.in_rdy", 0, 32'(in_rdy), 32'd0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    chk("flush.busy", 0, 32'(busy), 32'd0);
    chk("flush.out_vld", 0, 32'(out_vld), 32'd0);
    step(1, 8'h20, 0, 1'b0);
    step(1, 8'h05, 0, 1'b0);
    chk_all("flush.cmd", 0, 0, 1, 1, 0, 8'h20, 32'h00000005, 3'd1, 8'd255);

    // flush while holding with out_rdy high: command discarded
    step(0, 8'h00, 1, 1'b1);
    chk("flush_hold.out_vld", 0, 32'(out_vld), 32'd0);
    chk("flush_hold.busy", 0, 32'(busy), 32'd0);
    chk("flush_hold.err_count", 0, 32'(err_count), 32'd255);

    // asynchronous reset between edges while in PAYLOAD
    step(1, 8'h02, 1, 1'b0);
    step(1, 8'h00, 1, 1'b0);
    chk("areset.pre_busy", 0, 32'(busy), 32'd1);
    in_vld = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_all("areset", 0, 1, 0, 0, 0, 8'h00, 32'h0, 3'd0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 8'h02, 1, 1'b0);
    step(1, 8'h00, 1, 1'b0);
    step(1, 8'h10, 0, 1'b0);
    chk_all("post_reset", 0, 0, 1, 1, 0, 8'h02, 32'h00000010, 3'd2, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
